// File: rtl/rvm_mem_arbiter.sv
// Shares one single-outstanding memory port between NUM_CH requesters using
// round-robin or fixed-priority arbitration, with an optional stall timeout.
module rvm_mem_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_CH-1:0]    req_valid,
    output logic [NUM_CH-1:0]    req_ready,
    input  logic [NUM_CH-1:0]    req_wen,
    input  logic [NUM_CH*32-1:0] req_addr,
    input  logic [NUM_CH*32-1:0] req_wdata,
    input  logic [NUM_CH*4-1:0]  req_ben,
    output logic [NUM_CH-1:0]    rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_error,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_w_en,
    output logic                 mem_c_en,
    output logic [3:0]           mem_b_en,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_error,
    input  logic                 mem_stall
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_next;
    logic [IDX_W-1:0]    ch_q;
    logic                wen_q;
    logic [31:0]         addr_q, wdata_q;
    logic [3:0]          ben_q;
    logic [31:0]         stall_cnt_q;
    logic [NUM_CH-1:0]   rsp_valid_q;
    logic [31:0]         rdata_q;
    logic                error_q;

    logic [31:0]         ch_addr  [NUM_CH];
    logic [31:0]         ch_wdata [NUM_CH];
    logic [3:0]          ch_ben   [NUM_CH];
    logic [IDX_W-1:0]    start_idx, cand_idx, grant_idx;
    logic                grant_found, grant, timeout_hit, done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_addr[g]  = req_addr[g*32 +: 32];
        assign ch_wdata[g] = req_wdata[g*32 +: 32];
        assign ch_ben[g]   = req_ben[g*4 +: 4];
    end

    // First asserted request at or after start_idx, wrapping at NUM_CH.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start_idx   = (ARB_MODE == 0) ? rr_ptr_q : '0;
        cand_idx    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_idx = IDX_W'((int'(start_idx) + i) % NUM_CH);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant       = resetn && (state_q == S_IDLE) && grant_found;
    assign timeout_hit = (TIMEOUT_CYC > 0) && (state_q == S_BUSY) && mem_stall &&
                         (stall_cnt_q == 32'(TIMEOUT_CYC - 1));
    assign done        = (state_q == S_BUSY) && (!mem_stall || timeout_hit);
    assign rr_next     = (ch_q == IDX_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = S_BUSY;
            S_BUSY:  if (done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        mem_c_en  = 1'b0;
        mem_w_en  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_b_en  = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == S_BUSY) begin
            mem_c_en  = 1'b1;
            mem_w_en  = wen_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_b_en  = ben_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the captured
    // request fields are reset too, which is cheap at this width.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            ch_q        <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ben_q       <= '0;
            stall_cnt_q <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (grant) begin
                ch_q        <= grant_idx;
                wen_q       <= req_wen[grant_idx];
                addr_q      <= ch_addr[grant_idx];
                wdata_q     <= ch_wdata[grant_idx];
                ben_q       <= ch_ben[grant_idx];
                stall_cnt_q <= '0;
            end else if (state_q == S_BUSY && mem_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (done) begin
                rsp_valid_q <= NUM_CH'(1) << ch_q;
                rdata_q     <= timeout_hit ? '0 : mem_rdata;
                error_q     <= timeout_hit | mem_error;
                if (ARB_MODE == 0) begin
                    rr_ptr_q <= rr_next;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule
